// File: rtl/approx_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_arith_pkg
// Purpose  : Shared constants and helpers for the approximate-adder flow:
//            mode encoding, default datapath widths and a reference
//            truncated-sum function at the default width.
// Revision : 1.0 - initial release
// ============================================================================
package approx_arith_pkg;

  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_T = 4;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_TRUNC = 1'b1;

  // Truncated sum at the default width. Masking the low T bits of both
  // operands before a full-width add gives exactly the upper-slice sum with
  // zeroed LSBs, and the carry out of the top bit is dropped by the width.
  function automatic logic [DEFAULT_N-1:0] trunc_sum(
    input logic [DEFAULT_N-1:0] a,
    input logic [DEFAULT_N-1:0] b
  );
    logic [DEFAULT_N-1:0] mask;
    mask = ~DEFAULT_N'((1 << DEFAULT_T) - 1);
    return (a & mask) + (b & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_add_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. Searches i_req from the pointer upward,
//            wrapping modulo R; the first set bit wins. The pointer moves to
//            winner+1 only on cycles where i_advance is high.
// Ports    : clk, rst    - clock, async active-high reset
//            i_req       - request vector (R bits)
//            i_advance   - grant was consumed this cycle
//            o_grant     - one-hot or zero grant
//            o_grant_id  - index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   i_req,
  input  logic           i_advance,
  output logic [R-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_id
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < R; i++) begin
      w_idx = IDW'((int'(r_ptr) + i) % R);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_id == IDW'(R - 1)) ? '0 : o_grant_id + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/truncated_adder.sv
`default_nettype none
// ============================================================================
// Module   : truncated_adder
// Purpose  : N-bit approximate adder that ignores the T least significant
//            bits of both operands; result LSBs are zero, carry-out dropped.
// Ports    : i_a, i_b - operands (N bits)
//            o_sum    - truncated sum (N bits)
// Revision : 1.0 - initial release
// ============================================================================
module truncated_adder #(
  parameter int N = 8,
  parameter int T = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);

  // Zeroing the low slice on both inputs means no carry can enter bit T,
  // so a plain N-bit add yields {a_hi + b_hi, T'b0}.
  localparam logic [N-1:0] c_hi_mask = ~N'((1 << T) - 1);

  assign o_sum = (i_a & c_hi_mask) + (i_b & c_hi_mask);

endmodule
`default_nettype wire

// File: rtl/approx_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_arbiter
// Purpose  : One shared approximate/exact adder serving R requesters through
//            a round-robin arbiter, with a single registered response slot
//            (valid/ready) and per-mode saturating operation counters.
// Ports    : clk, rst              - clock, async active-high reset
//            req_valid/req_ready   - per-requester handshake (R bits)
//            req_a, req_b          - packed operands, requester i at [i*N +: N]
//            req_trunc             - per-requester mode (1 = truncated)
//            rsp_valid/rsp_ready   - response handshake
//            rsp_sum/rsp_id/rsp_trunc - result, winner index, mode used
//            cnt_clr               - synchronous clear of both counters
//            cnt_trunc/cnt_exact   - accepted-op counters (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module approx_add_arbiter
  import approx_arith_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int T   = DEFAULT_T,
  parameter int R   = 4,
  parameter int IDW = 2,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R-1:0]   req_trunc,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_sum,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_trunc,
  input  logic           cnt_clr,
  output logic [CW-1:0]  cnt_trunc,
  output logic [CW-1:0]  cnt_exact
);

  localparam logic [CW-1:0] c_cnt_max = '1;

  logic [R-1:0]   w_grant;
  logic [IDW-1:0] w_win;
  logic           w_can_accept;
  logic           w_accept;
  logic [N-1:0]   w_a;
  logic [N-1:0]   w_b;
  logic           w_mode;
  logic [N-1:0]   w_sum_trunc;
  logic [N-1:0]   w_sum_exact;
  logic [N-1:0]   w_sum;

  logic           r_rsp_valid;
  logic [N-1:0]   r_rsp_sum;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_trunc;
  logic [CW-1:0]  r_cnt_trunc;
  logic [CW-1:0]  r_cnt_exact;

  // The slot can take a new result if empty or being drained this cycle.
  assign w_can_accept = !r_rsp_valid || rsp_ready;
  // Gated by rst so nothing is handed out while the async reset is held.
  assign req_ready    = rst ? '0 : (w_grant & {R{w_can_accept}});
  assign w_accept     = |req_ready;

  rr_arbiter #(
    .R   (R),
    .IDW (IDW)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_advance  (w_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_win)
  );

  assign w_a    = req_a[w_win*N +: N];
  assign w_b    = req_b[w_win*N +: N];
  assign w_mode = req_trunc[w_win];

  truncated_adder #(
    .N (N),
    .T (T)
  ) u_truncated_adder (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum_trunc)
  );

  assign w_sum_exact = w_a + w_b;
  assign w_sum       = (w_mode == MODE_TRUNC) ? w_sum_trunc : w_sum_exact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
      r_rsp_trunc <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= w_sum;
      r_rsp_id    <= w_win;
      r_rsp_trunc <= w_mode;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Clear has priority, so an op accepted in the clear cycle is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_trunc <= '0;
      r_cnt_exact <= '0;
    end else if (cnt_clr) begin
      r_cnt_trunc <= '0;
      r_cnt_exact <= '0;
    end else if (w_accept) begin
      if (w_mode == MODE_TRUNC) begin
        if (r_cnt_trunc != c_cnt_max) r_cnt_trunc <= r_cnt_trunc + 1'b1;
      end else begin
        if (r_cnt_exact != c_cnt_max) r_cnt_exact <= r_cnt_exact + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;
  assign rsp_trunc = r_rsp_trunc;
  assign cnt_trunc = r_cnt_trunc;
  assign cnt_exact = r_cnt_exact;

endmodule
`default_nettype wire

// File: tb/tb_approx_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_add_arbiter
// Purpose  : Directed self-checking bench for approx_add_arbiter
//            (N=8, T=4, R=4, counters narrowed to 4 bits for saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_add_arbiter;

  localparam int N   = 8;
  localparam int T   = 4;
  localparam int R   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_trunc;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_sum;
  logic [IDW-1:0] rsp_id;
  logic           rsp_trunc;
  logic           cnt_clr;
  logic [CW-1:0]  cnt_trunc;
  logic [CW-1:0]  cnt_exact;

  int n_vec  = 0;
  int n_miss = 0;

  approx_add_arbiter #(
    .N (N), .T (T), .R (R), .IDW (IDW), .CW (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_trunc (req_trunc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_trunc (rsp_trunc),
    .cnt_clr   (cnt_clr),
    .cnt_trunc (cnt_trunc),
    .cnt_exact (cnt_exact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents one request, lets one edge pass, drops it.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic tr);
    req_valid           = '0;
    req_valid[id]       = 1'b1;
    req_a[id*N +: N]    = a;
    req_b[id*N +: N]    = b;
    req_trunc[id]       = tr;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  // Requester i: a = 0x10*(i+1), b = i+1, exact -> sum 0x11*(i+1).
  task automatic load_rr_ops();
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = 8'(16 * (i + 1));
      req_b[i*N +: N] = 8'(i + 1);
    end
    req_trunc = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_id[5];
    logic [7:0] exp_sum[5];

    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_trunc = '0;
    rsp_ready = 1'b1; cnt_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_sum",   32'(rsp_sum),   0);
    check_eq("rst_rsp_id",    32'(rsp_id),    0);
    check_eq("rst_rsp_trunc", 32'(rsp_trunc), 0);
    check_eq("rst_cnt_trunc", 32'(cnt_trunc), 0);
    check_eq("rst_cnt_exact", 32'(cnt_exact), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0; req_valid = '0;
    @(negedge clk);

    // Single truncated op from requester 2: 0x3_ + 0x2_ -> 0x50.
    req_valid = 4'b0100; req_a[2*N +: N] = 8'h37; req_b[2*N +: N] = 8'h2B; req_trunc[2] = 1'b1;
    #1 check_eq("t1_req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); @(negedge clk); req_valid = '0;
    check_eq("t1_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t1_rsp_sum",   32'(rsp_sum),   32'h50);
    check_eq("t1_rsp_id",    32'(rsp_id),    2);
    check_eq("t1_rsp_trunc", 32'(rsp_trunc), 1);
    check_eq("t1_cnt_trunc", 32'(cnt_trunc), 1);
    check_eq("t1_cnt_exact", 32'(cnt_exact), 0);
    @(posedge clk); @(negedge clk);
    check_eq("t1_drained", 32'(rsp_valid), 0);

    // Idle clear.
    cnt_clr = 1'b1;
    @(posedge clk); @(negedge clk); cnt_clr = 1'b0;
    check_eq("clr_cnt_trunc", 32'(cnt_trunc), 0);
    check_eq("clr_cnt_exact", 32'(cnt_exact), 0);

    // Wrap-around: carries out of bit 7 are dropped in both modes.
    issue(0, 8'hF0, 8'h20, 1'b0);
    check_eq("wrap_exact_sum", 32'(rsp_sum), 32'h10);
    issue(1, 8'hFF, 8'h01, 1'b1);   // hi nibbles F + 0 = F -> 0xF0
    check_eq("wrap_trunc_sum", 32'(rsp_sum), 32'hF0);
    check_eq("wrap_trunc_mode", 32'(rsp_trunc), 1);
    issue(2, 8'hFF, 8'h01, 1'b0);
    check_eq("wrap_exact2_sum", 32'(rsp_sum), 32'h00);
    check_eq("wrap_cnt_trunc", 32'(cnt_trunc), 1);
    check_eq("wrap_cnt_exact", 32'(cnt_exact), 2);

    // Round-robin with all four valid: pointer is parked at 0 first.
    issue(3, 8'h00, 8'h00, 1'b0);
    load_rr_ops();
    req_valid = 4'b1111;
    exp_id  = '{0, 1, 2, 3, 0};
    exp_sum = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check_eq($sformatf("rr_all_id%0d", k),  32'(rsp_id),  32'(exp_id[k]));
      check_eq($sformatf("rr_all_sum%0d", k), 32'(rsp_sum), 32'(exp_sum[k]));
    end
    req_valid = '0;
    issue(3, 8'h00, 8'h00, 1'b0);
    load_rr_ops();
    req_valid = 4'b1101;
    exp_id = '{0, 2, 3, 0, 0};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      check_eq($sformatf("rr_skip_id%0d", k), 32'(rsp_id), 32'(exp_id[k]));
    end
    req_valid = '0;
    check_eq("rr_cnt_exact", 32'(cnt_exact), 13);
    @(posedge clk); @(negedge clk);

    // Backpressure: a pending result must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(2, 8'h12, 8'h34, 1'b0);
    check_eq("bp_first_sum", 32'(rsp_sum), 32'h46);
    req_valid = 4'b0001; req_a[7:0] = 8'h05; req_b[7:0] = 8'h06; req_trunc[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq($sformatf("bp_req_ready%0d", k), 32'(req_ready), 0);
      @(posedge clk); @(negedge clk);
      check_eq($sformatf("bp_valid%0d", k), 32'(rsp_valid), 1);
      check_eq($sformatf("bp_sum%0d", k),   32'(rsp_sum),   32'h46);
      check_eq($sformatf("bp_id%0d", k),    32'(rsp_id),    2);
      check_eq($sformatf("bp_cnt%0d", k),   32'(cnt_exact), 14);
    end
    rsp_ready = 1'b1;
    #1 check_eq("bp_drain_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); @(negedge clk); req_valid = '0;
    check_eq("bp_new_valid", 32'(rsp_valid), 1);
    check_eq("bp_new_id",    32'(rsp_id),    0);
    check_eq("bp_new_sum",   32'(rsp_sum),   32'h0B);
    check_eq("bp_new_cnt",   32'(cnt_exact), 15);
    @(posedge clk); @(negedge clk);

    // Saturation of both 4-bit counters.
    cnt_clr = 1'b1;
    @(posedge clk); @(negedge clk); cnt_clr = 1'b0;
    for (int k = 0; k < 15; k++) issue(k % 4, 8'h11, 8'h22, 1'b1);
    check_eq("sat_trunc_max", 32'(cnt_trunc), 15);
    issue(0, 8'h11, 8'h22, 1'b1);
    check_eq("sat_trunc_hold", 32'(cnt_trunc), 15);
    check_eq("sat_trunc_sum",  32'(rsp_sum),   32'h30);
    for (int k = 0; k < 16; k++) issue(k % 4, 8'h01, 8'h02, 1'b0);
    check_eq("sat_exact_hold", 32'(cnt_exact), 15);
    check_eq("sat_exact_sum",  32'(rsp_sum),   32'h03);

    // Clear coinciding with an accept: op proceeds but is not counted.
    cnt_clr = 1'b1;
    issue(1, 8'h80, 8'h80, 1'b1);   // 8 + 8 = 0x10 -> 0 in 4 bits
    cnt_clr = 1'b0;
    check_eq("clracc_cnt_trunc", 32'(cnt_trunc), 0);
    check_eq("clracc_cnt_exact", 32'(cnt_exact), 0);
    check_eq("clracc_valid",     32'(rsp_valid), 1);
    check_eq("clracc_id",        32'(rsp_id),    1);
    check_eq("clracc_sum",       32'(rsp_sum),   32'h00);

    // Async reset mid-stream.
    load_rr_ops();
    req_valid = 4'b1111;
    @(posedge clk); @(negedge clk);
    check_eq("ar_pre_valid", 32'(rsp_valid), 1);
    #2 rst = 1'b1;
    #1 check_eq("ar_valid",     32'(rsp_valid), 0);
    check_eq("ar_req_ready",    32'(req_ready), 0);
    check_eq("ar_cnt_exact",    32'(cnt_exact), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check_eq("ar_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); @(negedge clk);
    check_eq("ar_first_id",    32'(rsp_id),    0);
    check_eq("ar_first_valid", 32'(rsp_valid), 1);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
